// File: rtl/class_hvec_seq.sv
// Class hypervector sequencer: walks the class ROM class by class, frame by
// frame, and streams each captured frame with its tags over valid/ready.
module class_hvec_seq #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic [CLASS_ID_W-1:0]         out_class_id,
    output logic [FRAME_IDX_W-1:0]        out_frame_index,
    output logic                          out_last_frame,
    output logic                          out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CLASS_ID_W-1:0]  LAST_CLASS = CLASS_ID_W'(NUM_CLASSES - 1);
    localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);

    logic [1:0]                    r_state;
    logic                          r_settle;
    logic [CLASS_ID_W-1:0]         r_cid;
    logic [FRAME_IDX_W-1:0]        r_fidx;
    logic [DI_PARALLEL_W_BITS-1:0] r_data;
    logic [CLASS_ID_W-1:0]         r_tag_cid;
    logic [FRAME_IDX_W-1:0]        r_tag_fidx;
    logic                          r_valid;
    logic                          r_last_frame;
    logic                          r_last;

    logic w_in_run;
    logic w_in_drain;
    logic w_abort;
    logic w_hs;
    logic w_load;
    logic w_frame_end;
    logic w_class_end;
    logic w_final;

    assign w_in_run    = (r_state == S_RUN);
    assign w_in_drain  = (r_state == S_DRAIN);
    assign w_abort     = abort && (w_in_run || w_in_drain);
    assign w_hs        = r_valid && out_ready;
    // The first RUN cycle only lets the ROM address settle; no capture.
    assign w_load      = w_in_run && !r_settle && !abort
                         && (!r_valid || out_ready);
    assign w_frame_end = (r_fidx == LAST_FRAME);
    assign w_class_end = (r_cid == LAST_CLASS);
    assign w_final     = w_frame_end && w_class_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_settle <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_settle <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_settle <= 1'b0;
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_load && w_final) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ROM address counters; they stop on the final address rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cid  <= '0;
            r_fidx <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cid  <= '0;
            r_fidx <= '0;
        end else if (w_load && !w_final) begin
            if (w_frame_end) begin
                r_fidx <= '0;
                r_cid  <= r_cid + 1'b1;
            end else begin
                r_fidx <= r_fidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_tag_cid  <= '0;
            r_tag_fidx <= '0;
        end else if (w_load) begin
            r_data     <= class_vec_in;
            r_tag_cid  <= r_cid;
            r_tag_fidx <= r_fidx;
        end
    end

    // Abort wins over a coincident handshake: that beat is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_last_frame <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_abort) begin
            r_valid      <= 1'b0;
            r_last_frame <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_load) begin
            r_valid      <= 1'b1;
            r_last_frame <= w_frame_end;
            r_last       <= w_final;
        end else if (w_in_drain && w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign busy            = w_in_run || w_in_drain;
    assign done            = (r_state == S_DONE);
    assign frame_id        = r_cid;
    assign frame_index     = r_fidx;
    assign out_valid       = r_valid;
    assign out_data        = r_data;
    assign out_class_id    = r_tag_cid;
    assign out_frame_index = r_tag_fidx;
    assign out_last_frame  = r_last_frame;
    assign out_last        = r_last;

endmodule

// File: tb/tb_class_hvec_seq.sv
// Scoreboard bench for class_hvec_seq: sweeps, backpressure, abort,
// ignored start and asynchronous reset.
module tb_class_hvec_seq;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  cid;
        logic [1:0]  fidx;
        logic        lastf;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  frame_id;
    logic [1:0]  frame_index;
    logic [63:0] class_vec_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  out_class_id;
    logic [1:0]  out_frame_index;
    logic        out_last_frame;
    logic        out_last;

    class_hvec_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .frame_id(frame_id), .frame_index(frame_index),
        .class_vec_in(class_vec_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_class_id(out_class_id),
        .out_frame_index(out_frame_index),
        .out_last_frame(out_last_frame), .out_last(out_last)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    hs_cnt = 0;
    int    first_hs = 0;
    int    last_hs = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    rdy_mode = 1;
    int    ph = 0;
    bit    stall_prev = 0;
    beat_t held;
    beat_t q[$];

    function automatic logic [63:0] rom(input logic [2:0] c,
                                        input logic [1:0] f);
        logic [63:0] k;
        k = 64'h9E3779B97F4A7C15 * {59'd0, c, f} + 64'h1234;
        return k ^ {32'(c) + 32'h55, 30'd0, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always_comb class_vec_in = rom(frame_id, frame_index);

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ready generator: 0 low, 1 high, 2 pattern 1,0,0,1.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: begin
                out_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                chk("hold_data", out_data, held.data);
                chk("hold_tag", {59'd0, out_class_id, out_frame_index},
                    {59'd0, held.cid, held.fidx});
            end
            stall_prev = out_valid && !out_ready && !abort;
            held.data = out_data;
            held.cid = out_class_id;
            held.fidx = out_frame_index;
            if (out_valid && out_ready && !abort) begin
                beat_t e;
                hs_cnt++;
                if (hs_cnt == 1) first_hs = cyc;
                last_hs = cyc;
                chk("rom_word", out_data, rom(out_class_id, out_frame_index));
                if (q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("data", out_data, e.data);
                    chk("tags", {59'd0, out_class_id, out_frame_index},
                        {59'd0, e.cid, e.fidx});
                    chk("last_frame", 64'(out_last_frame), 64'(e.lastf));
                    chk("last", 64'(out_last), 64'(e.last));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic push_sweep();
        beat_t b;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 3; f++) begin
                b.cid = 3'(c);
                b.fidx = 2'(f);
                b.data = rom(b.cid, b.fidx);
                b.lastf = (f == 2);
                b.last = (c == 7 && f == 2);
                q.push_back(b);
            end
        end
    endtask

    task automatic clr();
        hs_cnt = 0;
        done_cnt = 0;
        first_hs = 0;
        last_hs = 0;
    endtask

    task automatic do_start();
        push_sweep();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0;
        bit seen;
        n0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done_cnt > n0) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_hs(input int n, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (hs_cnt >= n) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, out_data, 64'd0);
        chk({tag, "_tags"}, {59'd0, out_class_id, out_frame_index}, 64'd0);
        chk({tag, "_addr"}, {59'd0, frame_id, frame_index}, 64'd0);
        chk({tag, "_flags"}, {60'd0, out_last_frame, out_last, busy, done},
            64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        #22;
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Full sweep with ready held high, including first-beat latency.
        clr();
        rdy_mode = 1;
        do_start();
        @(negedge clk);
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c3", 64'(out_valid), 64'd1);
        wait_done("t1_done_seen");
        chk("t1_beats", 64'(hs_cnt), 64'd24);
        chk("t1_b2b", 64'(last_hs - first_hs), 64'd23);
        chk("t1_done_lat", 64'(done_cyc - last_hs), 64'd1);
        chk("t1_q_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        chk("t1_busy_off", 64'(busy), 64'd0);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);

        // Backpressure 1,0,0,1.
        clr();
        ph = 0;
        rdy_mode = 2;
        do_start();
        wait_done("t2_done_seen");
        chk("t2_beats", 64'(hs_cnt), 64'd24);
        chk("t2_q_empty", 64'(q.size()), 64'd0);
        rdy_mode = 1;

        // Abort right after the 10th handshake.
        clr();
        do_start();
        wait_hs(10, "t3_hs10");
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t3_valid_off", 64'(out_valid), 64'd0);
        chk("t3_busy_off", 64'(busy), 64'd0);
        chk("t3_last_off", {62'd0, out_last, out_last_frame}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_done", 64'(done_cnt), 64'd0);
        chk("t3_beats", 64'(hs_cnt), 64'd10);
        q.delete();
        clr();
        do_start();
        wait_done("t3_fresh_done");
        chk("t3_fresh_beats", 64'(hs_cnt), 64'd24);

        // Second start during beat 5 is ignored.
        clr();
        do_start();
        wait_hs(5, "t4_hs5");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t4_done_seen");
        repeat (8) @(posedge clk);
        #1;
        chk("t4_beats", 64'(hs_cnt), 64'd24);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);
        chk("t4_q_empty", 64'(q.size()), 64'd0);

        // Async reset while a beat is stalled.
        clr();
        rdy_mode = 0;
        do_start();
        for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk);
        chk("t5_valid_up", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_zero("t5_async");
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        rdy_mode = 1;
        clr();
        do_start();
        wait_done("t5_resweep_done");
        chk("t5_resweep_beats", 64'(hs_cnt), 64'd24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/class_hvec_seq.md
Name: class_hvec_seq

Overview:
- Sequencer that walks the class hypervector ROM (class_hvec_gen) class by class, frame by frame.
- Drives the ROM address (frame_id, frame_index) and captures the combinational ROM word.
- Streams frames over a valid/ready interface to the downstream similarity/distance datapath, with per-frame and per-class tags.
- Sits between the inference control FSM (start/abort/done) and the associative-search unit.

Parameters:
- DI_PARALLEL_W_BITS, 64, width of one class-vector frame (ROM word width)
- NUM_CLASSES, 8, number of classes to sweep (1..8)
- NUM_FRAMES, 3, frames per class vector (1..4)
- CLASS_ID_W, 3, width of frame_id / class tag
- FRAME_IDX_W, 2, width of frame_index / frame tag

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin a full sweep; honoured only in IDLE
- abort  in  1  synchronous cancel of the sweep in progress
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last beat is accepted
- frame_id  out  CLASS_ID_W  ROM class address
- frame_index  out  FRAME_IDX_W  ROM frame address
- class_vec_in  in  DI_PARALLEL_W_BITS  combinational ROM data for the current address
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  DI_PARALLEL_W_BITS  captured class-vector frame
- out_class_id  out  CLASS_ID_W  class tag of the beat
- out_frame_index  out  FRAME_IDX_W  frame tag of the beat
- out_last_frame  out  1  beat is frame NUM_FRAMES-1 of its class
- out_last  out  1  beat is the final beat of the sweep

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - frame_id, frame_index, out_data, out_class_id and out_frame_index all go to 0.
  - out_valid, out_last_frame, out_last, busy and done all go to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> counters cleared to (0,0), go to RUN.
  - start while not in IDLE is ignored.
- RUN:
  - Load condition: load = (!out_valid || out_ready).
  - On load:
    - Capture out_data <= class_vec_in and the current counters into the tags.
    - Set out_valid=1.
    - Set out_last_frame = (frame_index==NUM_FRAMES-1).
    - Set out_last = (frame_id==NUM_CLASSES-1 && frame_index==NUM_FRAMES-1).
  - Counter advance on load:
    - frame_index increments.
    - At NUM_FRAMES-1, frame_index wraps to 0 and frame_id increments.
  - Loading the final address -> go to DRAIN; counters hold their value, no wrap.
  - No load (out_valid=1, out_ready=0): all outputs and counters hold stable (AXI-style; data must not change while valid is high and unaccepted).
- DRAIN:
  - out_valid && out_ready -> clear out_valid and out_last, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Throughput and latency:
  - First beat: start sampled at edge N -> out_valid high after edge N+2 (one cycle of ROM address settling in RUN, then capture).
  - With out_ready held high: one beat per cycle, NUM_CLASSES*NUM_FRAMES beats back to back.
  - With out_ready held high: done pulses exactly 1 cycle after the last handshake.
- Beat order: (class 0, frame 0..NUM_FRAMES-1), then class 1, and so on; never reordered or skipped.
- abort:
  - In RUN/DRAIN, on the next edge: clear out_valid, out_last and out_last_frame; go to IDLE; no done pulse.
  - abort takes priority over a simultaneous handshake; that beat is considered not delivered.
  - abort in IDLE/DONE has no effect (a DONE pulse still completes).
- Simultaneous start and abort in IDLE: start wins; abort is evaluated from RUN onward.
- frame_id and frame_index never exceed NUM_CLASSES-1 and NUM_FRAMES-1, including after abort.

Test Plan:
- Full sweep, out_ready=1: pulse start -> 24 beats on consecutive cycles.
  - Tags run (0,0),(0,1),(0,2),(1,0)…(7,2).
  - out_last_frame high on beats 3,6,…,24.
  - out_last only on beat 24.
  - done pulses 1 cycle after beat 24; busy low afterwards.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> out_data and tags stable during stalls, no beat lost or duplicated, 24 handshakes total, order identical to the full sweep.
- Data check: behavioural ROM model supplied on class_vec_in -> every out_data equals the model word at (out_class_id, out_frame_index).
- Abort mid-sweep: abort after the 10th handshake -> out_valid=0 next cycle, no done, busy=0; a new start yields a fresh sweep beginning at (0,0).
- Start ignored when busy: second start pulse during beat 5 -> sweep still ends at exactly 24 beats with a single done pulse.
- Async reset mid-sweep with out_valid=1 and out_ready=0 -> all outputs 0 immediately (no clock edge needed); FSM in IDLE after reset release.
